ps2_keystroke_decoder: RTL and testbench

- Keyboard front end for the typing game.
- Deserialises PS/2 (scan code set 2) frames from the keyboard and tracks make/break sequences.
- On release of a letter key, emits the 5-bit letter code plus a one-cycle key_released strobe, which the player-activity word checker consumes.
- Produces the keystroke/keyReleased stream that drives the word-compare logic.

---
 rtl/ps2_keystroke_decoder.sv | 150 +++++++++++++++
 tb/tb_ps2_keystroke_decoder.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/ps2_keystroke_decoder.sv
// rtl/ps2_keystroke_decoder.sv - PS/2 set-2 frame receiver emitting letter codes on key release
`timescale 1ns/1ps
module ps2_keystroke_decoder #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] keystroke,
  output logic       key_released,
  output logic       frame_error
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t                 state, stateNext;
  logic [SYNC_STAGES-1:0] clkSync, dataSync;
  logic                   psClkPrev;
  logic                   psClk, psData, fallEdge;
  logic [7:0]             shiftReg, byteReg;
  logic [2:0]             bitCnt;
  logic                   parityBit;
  logic [TW-1:0]          timer;
  logic                   timedOut, acceptByte, badFrame;
  logic                   byteValid, breakPending, extended;
  logic [4:0]             letter;

  function automatic logic [4:0] letterCode(input logic [7:0] sc);
    case (sc)
      8'h1C: letterCode = 5'd1;   8'h32: letterCode = 5'd2;   8'h21: letterCode = 5'd3;
      8'h23: letterCode = 5'd4;   8'h24: letterCode = 5'd5;   8'h2B: letterCode = 5'd6;
      8'h34: letterCode = 5'd7;   8'h33: letterCode = 5'd8;   8'h43: letterCode = 5'd9;
      8'h3B: letterCode = 5'd10;  8'h42: letterCode = 5'd11;  8'h4B: letterCode = 5'd12;
      8'h3A: letterCode = 5'd13;  8'h31: letterCode = 5'd14;  8'h44: letterCode = 5'd15;
      8'h4D: letterCode = 5'd16;  8'h15: letterCode = 5'd17;  8'h2D: letterCode = 5'd18;
      8'h1B: letterCode = 5'd19;  8'h2C: letterCode = 5'd20;  8'h3C: letterCode = 5'd21;
      8'h2A: letterCode = 5'd22;  8'h1D: letterCode = 5'd23;  8'h22: letterCode = 5'd24;
      8'h35: letterCode = 5'd25;  8'h1A: letterCode = 5'd26;
      default: letterCode = 5'd0;
    endcase
  endfunction

  // Synchronisers idle high so reset never fabricates a falling edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clkSync   <= '1;
      dataSync  <= '1;
      psClkPrev <= 1'b1;
    end else begin
      clkSync   <= {clkSync[SYNC_STAGES-2:0], ps2_clk};
      dataSync  <= {dataSync[SYNC_STAGES-2:0], ps2_data};
      psClkPrev <= psClk;
    end
  end

  assign psClk    = clkSync[SYNC_STAGES-1];
  assign psData   = dataSync[SYNC_STAGES-1];
  assign fallEdge = psClkPrev & ~psClk;
  assign timedOut = (state != IDLE) && !fallEdge && (timer == TW'(TIMEOUT_CYCLES));
  assign letter   = letterCode(byteReg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext  = state;
    acceptByte = 1'b0;
    badFrame   = 1'b0;
    if (timedOut) begin
      stateNext = IDLE;
    end else if (fallEdge) begin
      case (state)
        IDLE:   if (!psData) stateNext = DATA;
        DATA:   if (bitCnt == 3'd7) stateNext = PARITY;
        PARITY: stateNext = STOP;
        STOP: begin
          stateNext = IDLE;
          if ((^{shiftReg, parityBit}) && psData) acceptByte = 1'b1;
          else                                    badFrame   = 1'b1;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shiftReg  <= '0;
      bitCnt    <= '0;
      parityBit <= 1'b0;
      timer     <= '0;
      byteReg   <= '0;
      byteValid <= 1'b0;
    end else begin
      byteValid <= acceptByte;
      if (acceptByte) byteReg <= shiftReg;
      if (state == IDLE || fallEdge) timer <= '0;
      else if (!timedOut)            timer <= timer + TW'(1);
      if (fallEdge && !timedOut) begin
        case (state)
          IDLE:   bitCnt <= '0;
          DATA: begin
            shiftReg <= {psData, shiftReg[7:1]};
            bitCnt   <= bitCnt + 3'd1;
          end
          PARITY: parityBit <= psData;
          default: ;
        endcase
      end
    end
  end

  // Byte interpretation runs one cycle after acceptance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      keystroke    <= '0;
      key_released <= 1'b0;
      frame_error  <= 1'b0;
      breakPending <= 1'b0;
      extended     <= 1'b0;
    end else begin
      key_released <= 1'b0;
      frame_error  <= badFrame | timedOut;
      if (badFrame) begin
        breakPending <= 1'b0;
        extended     <= 1'b0;
      end else if (byteValid) begin
        if (byteReg == 8'hE0) begin
          extended <= 1'b1;
        end else if (byteReg == 8'hF0) begin
          breakPending <= 1'b1;
        end else begin
          if (breakPending && !extended && letter != 5'd0) begin
            keystroke    <= letter;
            key_released <= 1'b1;
          end
          breakPending <= 1'b0;
          extended     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ps2_keystroke_decoder.sv
// tb/tb_ps2_keystroke_decoder.sv - randomized bench for ps2_keystroke_decoder against a byte-level model
`timescale 1ns/1ps
module tb_ps2_keystroke_decoder;

  localparam int H   = 16;
  localparam int TMO = 200;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] keystroke;
  logic       key_released;
  logic       frame_error;

  ps2_keystroke_decoder #(.SYNC_STAGES(2), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .keystroke(keystroke), .key_released(key_released), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  int checkCount = 0, errorCount = 0;
  int totRel = 0, totErr = 0, bothHigh = 0;
  int mKey = 0, mRel = 0, mErr = 0;
  bit mBrk = 0, mExt = 0;

  logic [7:0] scanTab [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33, 8'h43,
                               8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
                               8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int letterOf(input logic [7:0] b);
    for (int i = 0; i < 26; i++) if (scanTab[i] == b) return i + 1;
    return 0;
  endfunction

  task automatic modelByte(input logic [7:0] b, output bit pulse);
    pulse = 0;
    if (b == 8'hE0) mExt = 1;
    else if (b == 8'hF0) mBrk = 1;
    else begin
      if (mBrk && !mExt && letterOf(b) != 0) begin
        mKey = letterOf(b);
        pulse = 1;
        mRel++;
      end
      mBrk = 0;
      mExt = 0;
    end
  endtask

  always @(negedge clk) begin
    if (key_released) totRel++;
    if (frame_error) totErr++;
    if (key_released && frame_error) bothHigh++;
  end

  task automatic driveBit(input bit v);
    ps2_data = v;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic sendFrame(input logic [7:0] b, input bit badPar = 0, input bit badStop = 0,
                           input string tag = "frame");
    logic [10:0] bits;
    bit expPulse, expErr;
    int relCnt = 0, relOff = 0, errCnt = 0, errOff = 0;
    bits = {~badStop, (~^b) ^ badPar, b, 1'b0};
    for (int i = 0; i < 10; i++) driveBit(bits[i]);
    ps2_data = bits[10];
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (key_released) begin relCnt++; relOff = k; end
      if (frame_error)  begin errCnt++; errOff = k; end
    end
    if (badPar || badStop) begin
      expErr = 1; expPulse = 0;
      mBrk = 0; mExt = 0; mErr++;
    end else begin
      expErr = 0;
      modelByte(b, expPulse);
    end
    checkEq({tag, ".relCount"}, relCnt, expPulse);
    if (expPulse) checkEq({tag, ".relLatency"}, relOff, 4);
    checkEq({tag, ".errCount"}, errCnt, expErr);
    if (expErr) checkEq({tag, ".errLatency"}, errOff, 3);
    checkEq({tag, ".keystroke"}, keystroke, mKey);
    repeat (H - 12) @(negedge clk);
    ps2_clk = 1'b1;
    ps2_data = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int errCnt;
    logic [7:0] r;
    repeat (5) @(negedge clk);
    checkEq("reset.keystroke", keystroke, 0);
    checkEq("reset.rel", key_released, 0);
    checkEq("reset.err", frame_error, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    sendFrame(8'h3B, 0, 0, "tp1.make");
    sendFrame(8'hF0, 0, 0, "tp1.f0");
    sendFrame(8'h3B, 0, 0, "tp1.brk");
    checkEq("tp1.key", keystroke, 10);

    repeat (3) sendFrame(8'h44, 0, 0, "tp2.make");
    sendFrame(8'hF0, 0, 0, "tp2.f0");
    sendFrame(8'h44, 0, 0, "tp2.brk");
    checkEq("tp2.key", keystroke, 15);

    sendFrame(8'hE0, 0, 0, "tp3.e0");
    sendFrame(8'hF0, 0, 0, "tp3.f0");
    sendFrame(8'h75, 0, 0, "tp3.up");
    sendFrame(8'hF0, 0, 0, "tp3.f0b");
    sendFrame(8'h1C, 0, 0, "tp3.a");
    checkEq("tp3.key", keystroke, 1);

    sendFrame(8'hF0, 1, 0, "tp4.badpar");
    sendFrame(8'h24, 0, 0, "tp4.make");
    checkEq("tp4.key", keystroke, 1);

    driveBit(1'b0);
    for (int i = 0; i < 5; i++) driveBit(1'($urandom_range(0, 1)));
    errCnt = 0;
    for (int k = 0; k < TMO + 80; k++) begin
      @(negedge clk);
      if (frame_error) errCnt++;
    end
    mErr++;
    checkEq("tp5.timeoutErr", errCnt, 1);
    sendFrame(8'hF0, 0, 0, "tp5.f0");
    sendFrame(8'h1A, 0, 0, "tp5.z");
    checkEq("tp5.key", keystroke, 26);

    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkEq("tp6.rstKey", keystroke, 0);
    checkEq("tp6.rstRel", key_released, 0);
    checkEq("tp6.rstErr", frame_error, 0);
    mKey = 0; mBrk = 0; mExt = 0;
    ps2_data = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    sendFrame(8'h2B, 0, 0, "tp6.make");
    sendFrame(8'hF0, 0, 0, "tp6.f0");
    sendFrame(8'h2B, 0, 0, "tp6.brk");
    checkEq("tp6.key", keystroke, 6);

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: begin
          sendFrame(8'hF0, 0, 0, "rnd.f0");
          sendFrame(scanTab[$urandom_range(0, 25)], 0, 0, "rnd.letterBrk");
        end
        1: repeat ($urandom_range(1, 2)) sendFrame(scanTab[$urandom_range(0, 25)], 0, 0, "rnd.make");
        2: begin
          sendFrame(8'hE0, 0, 0, "rnd.e0");
          if ($urandom_range(0, 1)) sendFrame(8'hF0, 0, 0, "rnd.e0f0");
          sendFrame(scanTab[$urandom_range(0, 25)], 0, 0, "rnd.ext");
        end
        3: begin
          r = 8'($urandom_range(0, 255));
          sendFrame(r, 0, 0, "rnd.byte");
        end
        4: begin
          bit bp, bs;
          r = 8'($urandom_range(0, 255));
          bp = 1'($urandom_range(0, 1));
          bs = bp ? 1'($urandom_range(0, 1)) : 1'b1;
          sendFrame(r, bp, bs, "rnd.corrupt");
        end
        default: begin
          r = 8'($urandom_range(0, 255));
          sendFrame(8'hF0, 0, 0, "rnd.f0n");
          sendFrame(r, 0, 0, "rnd.anyBrk");
        end
      endcase
    end

    checkEq("total.rel", totRel, mRel);
    checkEq("total.err", totErr, mErr);
    checkEq("total.bothHigh", bothHigh, 0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
